// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM state encoding and
// default parameter values used by pc_unit and pc_ras.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_STEP      = 4;
    localparam int unsigned DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry (the write pointer simply wraps) and occupancy saturates at DEPTH.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top_idx;
    logic [PW:0]      cnt;
    logic             full;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign top_idx = ptr - 1'b1;
    assign top     = mem[top_idx];
    assign count   = cnt;

    // Entry storage; contents are meaningless while occupancy is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= din;
        end
    end

    // Write pointer and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (!full) begin
                cnt <= cnt + 1'b1;
            end
        end else if (pop && (cnt != '0)) begin
            ptr <= ptr - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, redirect, call/return
// through a circular RAS, and a HALT trap for misaligned targets.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      STEP      = DEF_STEP,
    parameter int unsigned      RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             redirect,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             misalign,
    output logic             ras_err,
    output logic             ras_empty
);

    localparam int unsigned      PTR_BITS   = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] STEP_V     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    pc_state_t        state;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] ras_top;
    logic [PTR_BITS:0] ras_cnt;
    logic             ras_mt;
    logic             tgt_mis;
    logic             take;
    logic             ras_push;
    logic             ras_pop;

    assign pc_inc  = pc_q + STEP_V;
    assign tgt_mis = ((target & ALIGN_MASK) != '0);
    assign ras_mt  = (ras_cnt == '0);

    // Requests below redirect/hold only reach the RAS while running.
    assign take     = (state == ST_RUN) && !redirect && !hold;
    assign ras_push = take && call && !tgt_mis;
    assign ras_pop  = take && !call && ret && !ras_mt;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .top   (ras_top),
        .count (ras_cnt)
    );

    // FSM, priority mux and PC register with registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            pc_q     <= RESET_VEC;
            valid    <= 1'b0;
            misalign <= 1'b0;
            ras_err  <= 1'b0;
        end else begin
            misalign <= 1'b0;
            ras_err  <= 1'b0;
            case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                    valid <= 1'b1;
                end
                ST_RUN: begin
                    if (redirect) begin
                        if (tgt_mis) begin
                            state    <= ST_HALT;
                            valid    <= 1'b0;
                            misalign <= 1'b1;
                        end else begin
                            pc_q <= target;
                        end
                    end else if (hold) begin
                        pc_q <= pc_q;
                    end else if (call) begin
                        ras_err <= ret;
                        if (tgt_mis) begin
                            state    <= ST_HALT;
                            valid    <= 1'b0;
                            misalign <= 1'b1;
                        end else begin
                            pc_q <= target;
                        end
                    end else if (ret) begin
                        if (!ras_mt) begin
                            pc_q <= ras_top;
                        end else begin
                            pc_q    <= pc_inc;
                            ras_err <= 1'b1;
                        end
                    end else begin
                        pc_q <= pc_inc;
                    end
                end
                ST_HALT: begin
                    if (redirect && !tgt_mis) begin
                        state <= ST_RUN;
                        pc_q  <= target;
                        valid <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_HALT;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign out       = pc_q;
    assign ras_empty = ras_mt;

endmodule
